// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: in-order prefetch buffer between fetch and decode.
// The oldest entry is held in a dedicated output register (instructionOut),
// so the decoder sees a registered word with no input-to-output path.
// The storage array keeps every queued entry, head included. When the head
// is popped, the next-oldest word is loaded from the array into the output
// register at the same edge.
module ir_prefetch_queue #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int OPCODE_W = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Ld,
  input  logic [WIDTH-1:0]         instruction,
  input  logic                     Adv,
  input  logic                     Flush,
  output logic [WIDTH-1:0]         instructionOut,
  output logic [OPCODE_W-1:0]      opcode,
  output logic                     Valid,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head_q;
  logic             ovf_q;
  logic             is_full;
  logic             is_empty;
  logic             pop;
  logic             push;
  logic             drop;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);
  assign rd_next  = rd_ptr + PW'(1);

  // Accept decisions: Flush overrides everything, and a pop frees a slot for a same-cycle push.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (Flush) begin
      push = Ld;
    end else begin
      pop  = Adv && !is_empty;
      push = Ld && (!is_full || pop);
      drop = Ld && is_full && !pop;
    end
  end

  // Storage write; contents need no reset because cnt qualifies every read.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= instruction;
    end
  end

  // Pointer, count, head register and sticky overflow.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (Flush) begin
        // The surviving entry, if any, lands at wr_ptr, which becomes the new head.
        rd_ptr <= wr_ptr;
        cnt    <= Ld ? CW'(1) : '0;
        if (Ld) begin
          head_q <= instruction;
        end
      end else begin
        if (pop) begin
          rd_ptr <= rd_next;
        end
        if (push && !pop) begin
          cnt <= cnt + CW'(1);
        end else if (pop && !push) begin
          cnt <= cnt - CW'(1);
        end
        // With two or more entries the next-oldest is already in the array;
        // otherwise the pushed word (if any) becomes the head directly.
        if (pop && cnt != CW'(1)) begin
          head_q <= mem[rd_next];
        end else if (push && (is_empty || pop)) begin
          head_q <= instruction;
        end
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign instructionOut = head_q;
  assign opcode         = head_q[WIDTH-1 -: OPCODE_W];
  assign Count          = cnt;
  assign Valid          = !is_empty;
  assign Full           = is_full;
  assign Overflow       = ovf_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: a default instance (16/4/4) for directed
// scenarios and a 24/8/6 instance for the parameter sweep and random traffic.
// Each instance has a reference queue that is pushed when stimulus is
// accepted and popped as the head advances.
module tb_ir_prefetch_queue;

  logic        Clock;
  logic        Reset;

  logic        Ld0, Adv0, Flush0;
  logic [15:0] instruction0, instructionOut0;
  logic [3:0]  opcode0;
  logic        Valid0, Full0, Overflow0;
  logic [2:0]  Count0;

  logic        Ld1, Adv1, Flush1;
  logic [23:0] instruction1, instructionOut1;
  logic [5:0]  opcode1;
  logic        Valid1, Full1, Overflow1;
  logic [3:0]  Count1;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] mh0;
  logic        mo0;
  logic [23:0] q1[$];
  logic [23:0] mh1;
  logic        mo1;

  ir_prefetch_queue d0 (
    .Clock(Clock), .Reset(Reset), .Ld(Ld0), .instruction(instruction0),
    .Adv(Adv0), .Flush(Flush0), .instructionOut(instructionOut0),
    .opcode(opcode0), .Valid(Valid0), .Full(Full0), .Count(Count0),
    .Overflow(Overflow0)
  );

  ir_prefetch_queue #(.WIDTH(24), .DEPTH(8), .OPCODE_W(6)) d1 (
    .Clock(Clock), .Reset(Reset), .Ld(Ld1), .instruction(instruction1),
    .Adv(Adv1), .Flush(Flush1), .instructionOut(instructionOut1),
    .opcode(opcode1), .Valid(Valid1), .Full(Full1), .Count(Count1),
    .Overflow(Overflow1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one cycle on d0, advance the reference queue, return 1 time unit after the edge.
  task automatic step0(input logic ld, input logic [15:0] ins, input logic adv, input logic fl);
    logic pop;
    Ld0 = ld; instruction0 = ins; Adv0 = adv; Flush0 = fl;
    if (fl) begin
      q0.delete();
      if (ld) q0.push_back(ins);
    end else begin
      pop = adv && (q0.size() != 0);
      if (pop) void'(q0.pop_front());
      if (ld && (q0.size() < 4)) q0.push_back(ins);
      else if (ld) mo0 = 1'b1;
    end
    if (q0.size() != 0) mh0 = q0[0];
    @(posedge Clock); #1;
    Ld0 = 1'b0; Adv0 = 1'b0; Flush0 = 1'b0;
  endtask

  task automatic step1(input logic ld, input logic [23:0] ins, input logic adv, input logic fl);
    logic pop;
    Ld1 = ld; instruction1 = ins; Adv1 = adv; Flush1 = fl;
    if (fl) begin
      q1.delete();
      if (ld) q1.push_back(ins);
    end else begin
      pop = adv && (q1.size() != 0);
      if (pop) void'(q1.pop_front());
      if (ld && (q1.size() < 8)) q1.push_back(ins);
      else if (ld) mo1 = 1'b1;
    end
    if (q1.size() != 0) mh1 = q1[0];
    @(posedge Clock); #1;
    Ld1 = 1'b0; Adv1 = 1'b0; Flush1 = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #12;
    total++; if (Count0 !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", Count0); end
    total++; if (Valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", Valid0); end
    total++; if (instructionOut0 !== 16'h0) begin bad++; $display("FAIL reset_out got %h want 0", instructionOut0); end
    total++; if (Overflow0 !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", Overflow0); end
    Reset = 1'b0;
    @(posedge Clock); #1;
    step0(1'b1, 16'h5101, 1'b0, 1'b0);
    step0(1'b1, 16'h5102, 1'b0, 1'b0);
    step0(1'b1, 16'h5103, 1'b0, 1'b0);
    total++; if (Count0 !== 3'd3) begin bad++; $display("FAIL pre_reset_count got %0d want 3", Count0); end
    #3 Reset = 1'b1;
    #1;
    total++; if (Count0 !== 3'd0) begin bad++; $display("FAIL async_reset_count got %0d want 0", Count0); end
    total++; if (Valid0 !== 1'b0) begin bad++; $display("FAIL async_reset_valid got %b want 0", Valid0); end
    total++; if (instructionOut0 !== 16'h0) begin bad++; $display("FAIL async_reset_out got %h want 0", instructionOut0); end
    #1 Reset = 1'b0;
    q0.delete(); mh0 = '0; mo0 = 1'b0;
    q1.delete(); mh1 = '0; mo1 = 1'b0;
    step0(1'b1, 16'h1234, 1'b0, 1'b0);
    total++; if (Valid0 !== 1'b1) begin bad++; $display("FAIL post_reset_valid got %b want 1", Valid0); end
    total++; if (instructionOut0 !== 16'h1234) begin bad++; $display("FAIL post_reset_out got %h want 1234", instructionOut0); end
    total++; if (opcode0 !== 4'h1) begin bad++; $display("FAIL post_reset_opcode got %h want 1", opcode0); end
  endtask

  task automatic test_fifo_wrap();
    logic [15:0] exp_heads [4];
    exp_heads[0] = 16'hA003; exp_heads[1] = 16'hA004;
    exp_heads[2] = 16'hA005; exp_heads[3] = 16'hA006;
    step0(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) step0(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    total++; if (Full0 !== 1'b1 || Count0 !== 3'd4) begin bad++; $display("FAIL fifo_full got full=%b count=%0d want full=1 count=4", Full0, Count0); end
    total++; if (instructionOut0 !== 16'hA001) begin bad++; $display("FAIL fifo_first_head got %h want a001", instructionOut0); end
    step0(1'b0, 16'h0, 1'b1, 1'b0);
    step0(1'b0, 16'h0, 1'b1, 1'b0);
    step0(1'b1, 16'hA005, 1'b0, 1'b0);
    step0(1'b1, 16'hA006, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instructionOut0 !== exp_heads[i] || instructionOut0 !== mh0) begin
        bad++; $display("FAIL fifo_wrap_head%0d got %h want %h", i, instructionOut0, exp_heads[i]);
      end
      step0(1'b0, 16'h0, 1'b1, 1'b0);
    end
    total++; if (Valid0 !== 1'b0) begin bad++; $display("FAIL fifo_empty_valid got %b want 0", Valid0); end
    total++; if (instructionOut0 !== 16'hA006) begin bad++; $display("FAIL fifo_hold_out got %h want a006", instructionOut0); end
  endtask

  task automatic test_full_boundary();
    logic [15:0] exp_heads [4];
    exp_heads[0] = 16'hB002; exp_heads[1] = 16'hB003;
    exp_heads[2] = 16'hB004; exp_heads[3] = 16'hCAFE;
    for (int i = 1; i <= 4; i++) step0(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
    step0(1'b1, 16'hBEEF, 1'b0, 1'b0);
    total++; if (Count0 !== 3'd4 || instructionOut0 !== 16'hB001) begin bad++; $display("FAIL drop_unchanged got count=%0d out=%h want count=4 out=b001", Count0, instructionOut0); end
    total++; if (Overflow0 !== 1'b1) begin bad++; $display("FAIL drop_overflow got %b want 1", Overflow0); end
    step0(1'b1, 16'hCAFE, 1'b1, 1'b0);
    total++; if (Count0 !== 3'd4 || Full0 !== 1'b1) begin bad++; $display("FAIL full_pushpop_count got %0d want 4", Count0); end
    total++; if (Overflow0 !== 1'b1) begin bad++; $display("FAIL overflow_sticky got %b want 1", Overflow0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instructionOut0 !== exp_heads[i] || instructionOut0 !== mh0) begin
        bad++; $display("FAIL full_drain_head%0d got %h want %h", i, instructionOut0, exp_heads[i]);
      end
      step0(1'b0, 16'h0, 1'b1, 1'b0);
    end
    total++; if (Valid0 !== 1'b0 || instructionOut0 !== 16'hCAFE) begin bad++; $display("FAIL full_drain_end got valid=%b out=%h want valid=0 out=cafe", Valid0, instructionOut0); end
  endtask

  task automatic test_simultaneous();
    step0(1'b1, 16'h0001, 1'b0, 1'b0);
    step0(1'b1, 16'h0002, 1'b1, 1'b0);
    total++; if (instructionOut0 !== 16'h0002 || Count0 !== 3'd1 || Valid0 !== 1'b1) begin bad++; $display("FAIL pushpop_count1 got out=%h count=%0d want out=0002 count=1", instructionOut0, Count0); end
    step0(1'b0, 16'h0, 1'b1, 1'b0);
    step0(1'b1, 16'h0003, 1'b1, 1'b0);
    total++; if (instructionOut0 !== 16'h0003 || Count0 !== 3'd1) begin bad++; $display("FAIL pushpop_empty got out=%h count=%0d want out=0003 count=1", instructionOut0, Count0); end
    step0(1'b0, 16'h0, 1'b1, 1'b0);
    step0(1'b0, 16'h0, 1'b1, 1'b0);
    total++; if (Count0 !== 3'd0 || Valid0 !== 1'b0 || instructionOut0 !== 16'h0003) begin bad++; $display("FAIL underflow got count=%0d valid=%b out=%h want 0 0 0003", Count0, Valid0, instructionOut0); end
  endtask

  task automatic test_flush();
    step0(1'b1, 16'h1111, 1'b0, 1'b0);
    step0(1'b1, 16'h2222, 1'b0, 1'b0);
    step0(1'b1, 16'h3333, 1'b0, 1'b0);
    step0(1'b1, 16'h7F00, 1'b1, 1'b1);
    total++; if (Count0 !== 3'd1 || instructionOut0 !== 16'h7F00) begin bad++; $display("FAIL flush_load got count=%0d out=%h want count=1 out=7f00", Count0, instructionOut0); end
    total++; if (opcode0 !== 4'h7) begin bad++; $display("FAIL flush_opcode got %h want 7", opcode0); end
    step0(1'b1, 16'h4444, 1'b0, 1'b0);
    total++; if (instructionOut0 !== 16'h7F00 || Count0 !== 3'd2) begin bad++; $display("FAIL flush_order got out=%h count=%0d want 7f00 2", instructionOut0, Count0); end
    step0(1'b0, 16'h0, 1'b0, 1'b1);
    total++; if (Count0 !== 3'd0 || Valid0 !== 1'b0) begin bad++; $display("FAIL flush_empty got count=%0d valid=%b want 0 0", Count0, Valid0); end
    total++; if (Overflow0 !== mo0 || Overflow0 !== 1'b1) begin bad++; $display("FAIL flush_ovf got %b want 1", Overflow0); end
  endtask

  task automatic test_param_sweep();
    step1(1'b1, 24'hFC0000, 1'b0, 1'b0);
    total++; if (opcode1 !== 6'h3F || instructionOut1 !== 24'hFC0000) begin bad++; $display("FAIL wide_opcode got op=%h out=%h want 3f fc0000", opcode1, instructionOut1); end
    for (int i = 1; i < 7; i++) step1(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b0);
    total++; if (Full1 !== 1'b0 || Count1 !== 4'd7) begin bad++; $display("FAIL wide_not_full got full=%b count=%0d want 0 7", Full1, Count1); end
    step1(1'b1, 24'h2ABCDE, 1'b0, 1'b0);
    total++; if (Full1 !== 1'b1 || Count1 !== 4'd8) begin bad++; $display("FAIL wide_full got full=%b count=%0d want 1 8", Full1, Count1); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (instructionOut1 !== mh1) begin bad++; $display("FAIL wide_drain%0d got %h want %h", i, instructionOut1, mh1); end
      step1(1'b0, 24'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    logic ld, adv, fl;
    int   pld, padv;
    for (int i = 0; i < 2000; i++) begin
      pld  = (i < 1000) ? 65 : 45;
      padv = (i < 1000) ? 45 : 62;
      ld   = ($urandom_range(0, 99) < pld);
      adv  = ($urandom_range(0, 99) < padv);
      fl   = ($urandom_range(0, 99) < 3);
      step1(ld, 24'($urandom), adv, fl);
      total++;
      if (instructionOut1 !== mh1 || opcode1 !== mh1[23:18]) begin
        bad++; $display("FAIL rand_head cyc=%0d got %h want %h", i, instructionOut1, mh1);
      end
      total++;
      if (Count1 !== 4'(q1.size()) || Valid1 !== (q1.size() != 0) || Full1 !== (q1.size() == 8)) begin
        bad++; $display("FAIL rand_count cyc=%0d got count=%0d want %0d", i, Count1, q1.size());
      end
      total++;
      if (Overflow1 !== mo1) begin bad++; $display("FAIL rand_ovf cyc=%0d got %b want %b", i, Overflow1, mo1); end
    end
  endtask

  initial begin
    Ld0 = 1'b0; Adv0 = 1'b0; Flush0 = 1'b0; instruction0 = '0;
    Ld1 = 1'b0; Adv1 = 1'b0; Flush1 = 1'b0; instruction1 = '0;
    mh0 = '0; mo0 = 1'b0; mh1 = '0; mo1 = 1'b0;
    test_reset();
    test_fifo_wrap();
    test_full_boundary();
    test_simultaneous();
    test_flush();
    test_param_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction register. Holds up to DEPTH fetched instructions in order, so fetch can run ahead of decode. The oldest entry is presented as a registered instructionOut with a decoded opcode field. Sits between the memory/fetch stage and the control-unit decoder, and supports a branch flush.

Parameters:
WIDTH, 16, instruction width in bits (>= OPCODE_W+1)
DEPTH, 4, total entries including the head; power of two, >= 2
OPCODE_W, 4, opcode field width, taken from the MSBs of the instruction

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Ld  input  1  push request: instruction is written into the queue
instruction  input  WIDTH  instruction word from fetch
Adv  input  1  pop request: decoder has consumed the head
Flush  input  1  discard all queued entries (branch taken)
instructionOut  output  WIDTH  registered head instruction
opcode  output  OPCODE_W  instructionOut[WIDTH-1 -: OPCODE_W]
Valid  output  1  head holds an unconsumed instruction
Full  output  1  Count == DEPTH
Count  output  $clog2(DEPTH)+1  number of unconsumed entries, 0..DEPTH
Overflow  output  1  sticky flag: a push was dropped

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - Count=0, Valid=0, Overflow=0, instructionOut=0, opcode=0, read/write pointers=0.
  - Storage array contents don't care.
- All other state updates on the rising edge of Clock only.
- Outputs are driven from registers or from registered Count; no combinational path from any input to any output.
- Latency:
  - A push into an empty queue makes Valid=1 and instructionOut=instruction at the same edge (1 cycle, same as the legacy IR).
  - A pop advances instructionOut to the next-oldest entry at that edge.
- Accept rules, per edge, with priority Flush > Adv/Ld:
  - Flush=1: all queued entries discarded. If Ld=1 in the same cycle, that instruction is accepted as the sole entry (Count=1, Valid=1, instructionOut=instruction). Otherwise Count=0 and Valid=0. Adv is ignored. Overflow is unchanged.
  - Adv=1 with Valid=0: ignored (no underflow, no state change).
  - Ld=1 with Full=0: accepted.
  - Ld=1 with Full=1 and Adv=1: accepted (simultaneous pop frees a slot); Count stays DEPTH.
  - Ld=1 with Full=1 and Adv=0: instruction dropped, queue unchanged, Overflow set to 1.
  - Ld=1 and Adv=1 with Count=1: instructionOut=instruction, Count stays 1, Valid stays 1.
  - Ld=1 and Adv=1 with Count=0: Adv is ignored; the push proceeds as a normal push into empty.
- Count: +1 on accepted push only, -1 on effective pop only, unchanged when both occur.
- Pointers wrap modulo DEPTH. Order is strictly FIFO across wrap.
- Empty (Valid=0): instructionOut and opcode hold the last presented value; it is not cleared, only Reset clears it. The decoder must qualify on Valid.
- Overflow is cleared only by Reset.
- Full is decoded from registered Count; it is valid in the same cycle the fetch stage samples it.

Test Plan:
- Reset mid-stream: with Count=3, assert Reset between clock edges -> immediately Count=0, Valid=0, instructionOut=0, Overflow=0. After release, push 16'h1234 -> next edge Valid=1, instructionOut=16'h1234, opcode=4'h1.
- FIFO order and wrap: push 16'hA001..16'hA004 (Full=1, Count=4), pop 2, push 16'hA005 and 16'hA006, pop 4 -> heads appear in order A003, A004, A005, A006. Valid=0 after the last pop, and instructionOut holds 16'hA006.
- Full boundary:
  - At Count=4, Ld=1 with 16'hBEEF and Adv=0 -> queue unchanged, Overflow=1 and stays 1.
  - Next cycle, Ld=1 with 16'hCAFE and Adv=1 -> accepted, Count=4, CAFE is the last entry popped.
- Simultaneous push/pop edge cases:
  - Count=1 (head 16'h0001), Ld=1 with 16'h0002 and Adv=1 -> instructionOut=16'h0002, Count=1.
  - Count=0, Ld=1 with 16'h0003 and Adv=1 -> instructionOut=16'h0003, Count=1.
  - Count=0, Adv=1 alone -> no change.
- Flush: with Count=3, Flush=1 and Ld=1 with 16'h7F00 -> Count=1, instructionOut=16'h7F00, opcode=4'h7. Flush=1 with Ld=0 -> Count=0, Valid=0, Overflow unchanged.
- Parameter sweep: WIDTH=24, DEPTH=8, OPCODE_W=6 -> Full only at Count=8. opcode equals instructionOut[23:18] for pushed 24'hFC0000 (6'h3F). Run random push/pop against a reference queue model for 2000 cycles with no mismatch.
